// File: rtl/md_unit_pkg.sv
// Shared constants for the multiply/divide unit: MIPS funct codes and FSM states.
package md_unit_pkg;

  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_t;

  function automatic logic func_valid(input logic [5:0] f);
    return (f == FUNC_MULT) || (f == FUNC_MULTU) || (f == FUNC_DIV) || (f == FUNC_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and md_unit.
interface md_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            start;
  logic [5:0]      func;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            cancel;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, func, A, B, cancel,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, func, A, B, cancel,
    output busy, stall, done, hi, lo
  );

endinterface

// File: rtl/md_iter_core.sv
// Iteration datapath: 2*XLEN accumulator/remainder register with one XLEN-bit
// shift-add (multiply) or restoring shift-subtract (divide) step per enable.
module md_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              step,
  input  logic              div,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic [2*XLEN-1:0] acc
);

  logic [XLEN-1:0]   m;
  logic [XLEN:0]     tmp;
  logic [XLEN:0]     diff;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] acc_nx;

  always_comb begin
    tmp  = acc[2*XLEN-1:XLEN-1];
    diff = tmp - {1'b0, m};
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : '0);
    if (div) begin
      // Negative trial difference restores the shifted partial remainder.
      acc_nx = diff[XLEN] ? {tmp[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_nx = {sum, acc[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m   <= '0;
      acc <= '0;
    end else if (load) begin
      m   <= div ? b_mag : a_mag;
      acc <= {{XLEN{1'b0}}, (div ? a_mag : b_mag)};
    end else if (step) begin
      acc <= acc_nx;
    end
  end

endmodule

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO; owns FSM, counter, sign fix.
// Optional MD_FAST_MUL_EN: multiplies complete through a single-cycle product.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic     clk,
  input  logic     resetn,
  md_unit_if.slave bus
);

  md_state_t state, state_nx;

  logic [CNT_W-1:0]  cnt;
  logic              op_div;
  logic              sign_q;
  logic              sign_r;
  logic              bzero;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;

  logic              accept;
  logic              fast_hit;
  logic              load;
  logic              step;
  logic              commit;
  logic              core_div;
  logic              sa;
  logic              sb;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] prod_fix;
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   q_mag;
  logic [XLEN-1:0]   r_mag;
  logic [XLEN-1:0]   res_hi;
  logic [XLEN-1:0]   res_lo;

  assign accept = bus.start & (state == ST_IDLE) & func_valid(bus.func) & ~bus.cancel;
  assign sa     = ~bus.func[0] & bus.A[XLEN-1];
  assign sb     = ~bus.func[0] & bus.B[XLEN-1];
  assign a_mag  = sa ? -bus.A : bus.A;
  assign b_mag  = sb ? -bus.B : bus.B;

`ifdef MD_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_mag;
  assign fast_hit  = accept & ~bus.func[1];
  assign fast_mag  = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
  assign fast_prod = (sa ^ sb) ? -fast_mag : fast_mag;
`else
  assign fast_hit  = 1'b0;
  assign fast_prod = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = fast_hit ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (bus.cancel)                       state_nx = ST_IDLE;
        else if (cnt == CNT_W'(XLEN - 1))     state_nx = ST_FIX;
      end
      ST_FIX:  state_nx = bus.cancel ? ST_IDLE : ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    commit = 1'b0;
    case (state)
      ST_IDLE: load   = accept & ~fast_hit;
      ST_CALC: step   = ~bus.cancel;
      ST_FIX:  commit = ~bus.cancel;
      default: ;
    endcase
  end

  // Operation type must reach the core on the load edge, before op_div is registered.
  assign core_div = load ? bus.func[1] : op_div;

  md_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk   (clk),
    .resetn(resetn),
    .load  (load),
    .step  (step),
    .div   (core_div),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .acc   (acc)
  );

  assign prod_fix = sign_q ? -acc : acc;
  assign q_mag    = acc[XLEN-1:0];
  assign r_mag    = acc[2*XLEN-1:XLEN];

  // A zero divisor leaves the raw dividend in the remainder; sign_r restores A exactly.
  always_comb begin
    if (op_div) begin
      res_lo = bzero ? '1 : (sign_q ? -q_mag : q_mag);
      res_hi = sign_r ? -r_mag : r_mag;
    end else begin
      res_hi = prod_fix[2*XLEN-1:XLEN];
      res_lo = prod_fix[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      op_div <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      bzero  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= (state_nx == ST_CALC) || (state_nx == ST_FIX);
      done_q <= commit | fast_hit;
      cnt    <= step ? cnt + 1'b1 : '0;
      if (load) begin
        op_div <= bus.func[1];
        sign_q <= sa ^ sb;
        sign_r <= sa;
        bzero  <= (bus.B == '0);
      end
      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (fast_hit) begin
        hi_q <= fast_prod[2*XLEN-1:XLEN];
        lo_q <= fast_prod[XLEN-1:0];
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = busy_q | accept;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latency, signed/unsigned results,
// divide-by-zero, overflow, cancel, ignored starts and asynchronous reset.
module tb_md_unit;
  import md_unit_pkg::*;

`ifdef MD_FAST_MUL_EN
  localparam int   MUL_LAT  = 1;
  localparam logic MUL_BUSY = 1'b0;
`else
  localparam int   MUL_LAT  = 34;
  localparam logic MUL_BUSY = 1'b1;
`endif
  localparam int DIV_LAT = 34;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc;
  int   dones;

  md_unit_if #(.XLEN(32)) bus ();

  md_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.func  = f;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Cycle 1 is the cycle following the accept edge.
  task automatic wait_done(output int c);
    c = 1;
    while (bus.done !== 1'b1 && c < 200) begin
      @(posedge clk);
      #1 c++;
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.func   = 6'h00;
    bus.A      = '0;
    bus.B      = '0;
    bus.cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", {32'd0, bus.hi}, 64'd0);
    check("rst_lo", {32'd0, bus.lo}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    @(negedge clk) resetn = 1'b1;

    // 1: MULTU max*max
    @(negedge clk);
    bus.start = 1'b1; bus.func = FUNC_MULTU; bus.A = 32'hFFFF_FFFF; bus.B = 32'hFFFF_FFFF;
    #1 check("stall_accept", {63'd0, bus.stall}, 64'd1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("mul_busy", {63'd0, bus.busy}, {63'd0, MUL_BUSY});
    wait_done(cyc);
    check("multu_lat", cyc, MUL_LAT);
    check("multu_hi", {32'd0, bus.hi}, 64'hFFFF_FFFE);
    check("multu_lo", {32'd0, bus.lo}, 64'h0000_0001);
    @(posedge clk);
    #1 check("done_pulse", {63'd0, bus.done}, 64'd0);

    // 2: MULT -2*3, then back-to-back with a start presented during DONE
    issue(FUNC_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_done(cyc);
    check("mult_lat", cyc, MUL_LAT);
    check("mult_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
    check("mult_lo", {32'd0, bus.lo}, 64'hFFFF_FFFA);
    bus.start = 1'b1; bus.func = FUNC_DIVU; bus.A = 32'd9; bus.B = 32'd2;
    #1 check("done_start_stall", {63'd0, bus.stall}, 64'd0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("done_start_ignored", {63'd0, bus.busy}, 64'd0);
    issue(FUNC_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_done(cyc);
    check("b2b_lat", cyc, MUL_LAT);
    check("b2b_lo", {32'd0, bus.lo}, 64'hFFFF_FFFA);
    @(posedge clk);

    // 3: signed divides
    issue(FUNC_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_busy", {63'd0, bus.busy}, 64'd1);
    wait_done(cyc);
    check("div_lat", cyc, DIV_LAT);
    check("div_lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);
    check("div_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
    @(posedge clk);
    issue(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    check("ovf_lo", {32'd0, bus.lo}, 64'h8000_0000);
    check("ovf_hi", {32'd0, bus.hi}, 64'h0);
    @(posedge clk);
    issue(FUNC_DIV, 32'hFFFF_FFFB, 32'd0);
    wait_done(cyc);
    check("divz_s_lo", {32'd0, bus.lo}, 64'hFFFF_FFFF);
    check("divz_s_hi", {32'd0, bus.hi}, 64'hFFFF_FFFB);
    @(posedge clk);

    // 4: unsigned divides, incl. divide by zero
    issue(FUNC_DIVU, 32'd100, 32'd0);
    wait_done(cyc);
    check("divz_lat", cyc, DIV_LAT);
    check("divz_lo", {32'd0, bus.lo}, 64'hFFFF_FFFF);
    check("divz_hi", {32'd0, bus.hi}, 64'h0000_0064);
    @(posedge clk);
    issue(FUNC_DIVU, 32'd7, 32'd9);
    wait_done(cyc);
    check("divu_lo", {32'd0, bus.lo}, 64'd0);
    check("divu_hi", {32'd0, bus.hi}, 64'd7);
    bus.cancel = 1'b1;
    @(posedge clk);
    #1 bus.cancel = 1'b0;
    check("cancel_done_hi", {32'd0, bus.hi}, 64'd7);

    // Invalid func and cancel-with-start in IDLE are both rejected
    @(negedge clk);
    bus.start = 1'b1; bus.func = 6'h20; bus.A = 32'd1; bus.B = 32'd1;
    #1 check("bad_func_stall", {63'd0, bus.stall}, 64'd0);
    bus.func = FUNC_DIV; bus.cancel = 1'b1;
    #1 check("cancel_start_stall", {63'd0, bus.stall}, 64'd0);
    @(posedge clk);
    #1 bus.start = 1'b0; bus.cancel = 1'b0;
    check("rejected_busy", {63'd0, bus.busy}, 64'd0);

    // 5: cancel at cycle 10
    issue(FUNC_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 bus.cancel = 1'b1;
    @(posedge clk);
    #1 bus.cancel = 1'b0;
    check("cancel_busy", {63'd0, bus.busy}, 64'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.done === 1'b1) dones++;
    end
    check("cancel_no_done", dones, 0);
    check("cancel_hi", {32'd0, bus.hi}, 64'd7);
    check("cancel_lo", {32'd0, bus.lo}, 64'd0);

    // start while busy is ignored
    issue(FUNC_DIVU, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.func = FUNC_MULTU; bus.A = 32'd2; bus.B = 32'd2;
    #1 check("busy_stall", {63'd0, bus.stall}, 64'd1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    dones = 0;
    repeat (60) begin
      @(posedge clk);
      #1 if (bus.done === 1'b1) dones++;
    end
    check("busy_one_done", dones, 1);
    check("busy_lo", {32'd0, bus.lo}, 64'd333);
    check("busy_hi", {32'd0, bus.hi}, 64'd1);

    // 6: asynchronous reset mid-divide
    issue(FUNC_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (19) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_hi", {32'd0, bus.hi}, 64'd0);
    check("arst_lo", {32'd0, bus.lo}, 64'd0);
    check("arst_busy", {63'd0, bus.busy}, 64'd0);
    check("arst_done", {63'd0, bus.done}, 64'd0);
    @(negedge clk) resetn = 1'b1;
    issue(FUNC_MULTU, 32'd3, 32'd5);
    wait_done(cyc);
    check("post_rst_lat", cyc, MUL_LAT);
    check("post_rst_lo", {32'd0, bus.lo}, 64'd15);
    check("post_rst_hi", {32'd0, bus.hi}, 64'd0);
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
